// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch (F) and loader (L); fetch wins unless L is starved or holds the lock.
// Grant is combinational, read data returns 1 cycle after grant; a requester not granted sees ready=0 and must hold.
module imem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [31:0]       f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_valid,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_ready,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              locked,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        SHARE,
        LOCK
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_L
    } owner_t;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       lock_hold;
    logic       f_gnt;
    logic       l_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SHARE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        lock_hold  = 1'b0;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_nxt  = SHARE;
        owner_nxt  = OWN_NONE;
        starve_nxt = '0;

        // Dropping l_lock while in LOCK releases the port in the same cycle.
        lock_hold = (state == LOCK) && l_lock;

        if (!rst) begin
            if (lock_hold) begin
                l_gnt = l_valid;
            end else begin
                l_gnt = l_valid && (!f_valid || (starve_cnt == STARVE_LIM));
                f_gnt = f_valid && !l_gnt;
            end
        end

        if (lock_hold || (l_gnt && l_lock)) begin
            state_nxt = LOCK;
        end

        if (f_gnt) begin
            owner_nxt = OWN_F;
        end else if (l_gnt && !l_we) begin
            owner_nxt = OWN_L;
        end

        if (l_valid && !l_gnt) begin
            starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : 4'(starve_cnt + 4'd1);
        end
    end

    assign f_ready   = f_gnt;
    assign l_ready   = l_gnt;
    assign locked    = (state == LOCK);
    assign f_rvalid  = (owner == OWN_F);
    assign l_rvalid  = (owner == OWN_L);
    assign f_rdata   = mem_q;
    assign l_rdata   = mem_q;

    // Idle cycles park the address on the fetch PC so a later fetch grant sees no extra mux change.
    assign mem_addr  = rst   ? '0 :
                       l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    assign mem_we    = l_gnt && l_we;
    assign mem_wdata = l_wdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0], l_addr[31:ADDR_W+2], l_addr[1:0]};

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic against a rule-level model with a shadow memory.
module tb_imem_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_valid;
    logic [31:0]   f_addr;
    logic          f_ready;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_valid;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_lock;
    logic          l_ready;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          locked;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_ready(l_ready), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .locked(locked), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_q(mem_q)
    );

    function automatic logic [31:0] pat(int a);
        logic [7:0] b;
        b = a[7:0];
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Synchronous single-port memory: registered read, write at the edge.
    bit [31:0] mem [256];
    bit        wr  [256];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        mem_q <= wr[mem_addr] ? mem[mem_addr] : pat(int'(mem_addr));
    end

    // Reference model state
    logic [31:0] sh [256];
    bit          m_lock;
    int          m_starve;
    int          m_resp;      // 0 none, 1 fetch, 2 loader
    logic [31:0] m_data;
    bit          e_fr, e_lr, e_we;
    int          e_addr;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic model_comb();
        bit lock_now;
        lock_now = m_lock && l_lock;
        e_fr = 1'b0;
        e_lr = 1'b0;
        if (!rst) begin
            if (lock_now) begin
                e_lr = l_valid;
            end else if (f_valid && l_valid) begin
                e_lr = (m_starve >= SMAX);
                e_fr = !e_lr;
            end else begin
                e_fr = f_valid;
                e_lr = l_valid;
            end
        end
        if (rst)       e_addr = 0;
        else if (e_lr) e_addr = int'((l_addr >> 2) & 32'hFF);
        else           e_addr = int'((f_addr >> 2) & 32'hFF);
        e_we = e_lr && l_we;
    endtask

    task automatic model_seq();
        model_comb();
        if (rst) begin
            m_lock   = 1'b0;
            m_starve = 0;
            m_resp   = 0;
        end else begin
            m_resp = 0;
            if (e_fr) begin
                m_resp = 1;
                m_data = sh[e_addr];
            end else if (e_lr && !l_we) begin
                m_resp = 2;
                m_data = sh[e_addr];
            end
            if (e_we) sh[e_addr] = l_wdata;
            m_lock = (m_lock && l_lock) || (e_lr && l_lock);
            if (l_valid && !e_lr) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            else                  m_starve = 0;
        end
    endtask

    task automatic tick();
        model_seq();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_valid = 1'b1; l_valid = 1'b1; l_lock = 1'b1; l_we = 1'b1;
        f_addr = 32'h3FFC; l_addr = 32'h3044; l_wdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (f_ready !== 1'b0) $display("FAIL rst_f_ready got=%b exp=0", f_ready); else n_pass++;
            n_chk++; if (l_ready !== 1'b0) $display("FAIL rst_l_ready got=%b exp=0", l_ready); else n_pass++;
            n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else n_pass++;
            n_chk++; if (mem_addr !== 8'h00) $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); else n_pass++;
            tick();
        end
        rst = 1'b0; f_valid = 1'b0; l_valid = 1'b0; l_lock = 1'b0; l_we = 1'b0;
        #1;
        n_chk++; if (f_rvalid !== 1'b0) $display("FAIL rst_f_rvalid got=%b exp=0", f_rvalid); else n_pass++;
        n_chk++; if (l_rvalid !== 1'b0) $display("FAIL rst_l_rvalid got=%b exp=0", l_rvalid); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL rst_locked got=%b exp=0", locked); else n_pass++;
        tick();
    endtask

    task automatic test_fetch_stream();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f_valid = 1'b1;
            f_addr  = 32'h3000 + 32'(4 * i);
            #1;
            n_chk++; if (f_ready !== 1'b1) $display("FAIL fetch_ready[%0d] got=%b exp=1", i, f_ready); else n_pass++;
            n_chk++; if (mem_addr !== 8'(i)) $display("FAIL fetch_addr[%0d] got=%h exp=%h", i, mem_addr, 8'(i)); else n_pass++;
            if (i > 0) begin
                n_chk++; if (f_rvalid !== 1'b1) $display("FAIL fetch_rvalid[%0d] got=%b exp=1", i, f_rvalid); else n_pass++;
                n_chk++; if (f_rdata !== m_data) $display("FAIL fetch_rdata[%0d] got=%h exp=%h", i, f_rdata, m_data); else n_pass++;
            end
            tick();
        end
        f_valid = 1'b0;
        #1;
        n_chk++; if (f_rvalid !== 1'b1) $display("FAIL fetch_last_rvalid got=%b exp=1", f_rvalid); else n_pass++;
        n_chk++; if (f_rdata !== pat(7)) $display("FAIL fetch_last_rdata got=%h exp=%h", f_rdata, pat(7)); else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        l_valid = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h3010;
        for (int c = 0; c < 5; c++) begin
            f_valid = 1'b1;
            f_addr  = 32'h3100 + 32'(4 * c);
            #1;
            if (c < 4) begin
                n_chk++; if (l_ready !== 1'b0) $display("FAIL starve_l_denied[%0d] got=%b exp=0", c, l_ready); else n_pass++;
                n_chk++; if (f_ready !== 1'b1) $display("FAIL starve_f_ready[%0d] got=%b exp=1", c, f_ready); else n_pass++;
            end else begin
                n_chk++; if (l_ready !== 1'b1) $display("FAIL starve_l_grant got=%b exp=1", l_ready); else n_pass++;
                n_chk++; if (f_ready !== 1'b0) $display("FAIL starve_f_blocked got=%b exp=0", f_ready); else n_pass++;
                n_chk++; if (mem_addr !== 8'h04) $display("FAIL starve_mem_addr got=%h exp=04", mem_addr); else n_pass++;
            end
            tick();
        end
        l_valid = 1'b0;
        #1;
        n_chk++; if (l_rvalid !== 1'b1) $display("FAIL starve_l_rvalid got=%b exp=1", l_rvalid); else n_pass++;
        n_chk++; if (l_rdata !== pat(4)) $display("FAIL starve_l_rdata got=%h exp=%h", l_rdata, pat(4)); else n_pass++;
        n_chk++; if (f_rvalid !== 1'b0) $display("FAIL starve_f_rvalid got=%b exp=0", f_rvalid); else n_pass++;
        tick();
        f_valid = 1'b0;
    endtask

    task automatic test_lock();
        f_valid = 1'b0; l_valid = 1'b1; l_we = 1'b1; l_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            l_addr  = 32'h3000 + 32'(4 * k);
            l_wdata = $urandom;
            #1;
            n_chk++; if (l_ready !== 1'b1) $display("FAIL lock_l_ready[%0d] got=%b exp=1", k, l_ready); else n_pass++;
            n_chk++; if (f_ready !== 1'b0) $display("FAIL lock_f_ready[%0d] got=%b exp=0", k, f_ready); else n_pass++;
            n_chk++; if (mem_we !== 1'b1) $display("FAIL lock_mem_we[%0d] got=%b exp=1", k, mem_we); else n_pass++;
            n_chk++; if (mem_addr !== 8'(k)) $display("FAIL lock_mem_addr[%0d] got=%h exp=%h", k, mem_addr, 8'(k)); else n_pass++;
            n_chk++; if (locked !== (k != 0)) $display("FAIL lock_locked[%0d] got=%b exp=%b", k, locked, k != 0); else n_pass++;
            tick();
            f_valid = 1'b1;
            f_addr  = 32'h3000;
        end
        l_lock = 1'b0; l_valid = 1'b0;
        #1;
        n_chk++; if (f_ready !== 1'b1) $display("FAIL unlock_f_ready got=%b exp=1", f_ready); else n_pass++;
        n_chk++; if (locked !== 1'b1) $display("FAIL unlock_locked_still got=%b exp=1", locked); else n_pass++;
        tick();
        f_valid = 1'b0;
        #1;
        n_chk++; if (locked !== 1'b0) $display("FAIL unlock_locked got=%b exp=0", locked); else n_pass++;
        n_chk++; if (f_rdata !== sh[0]) $display("FAIL unlock_f_rdata got=%h exp=%h", f_rdata, sh[0]); else n_pass++;
        tick();
    endtask

    task automatic test_write_read();
        f_valid = 1'b0; l_lock = 1'b0;
        l_valid = 1'b1; l_we = 1'b1; l_addr = 32'h3020; l_wdata = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (l_ready !== 1'b1) $display("FAIL wr_l_ready got=%b exp=1", l_ready); else n_pass++;
        n_chk++; if (mem_addr !== 8'h08) $display("FAIL wr_mem_addr got=%h exp=08", mem_addr); else n_pass++;
        n_chk++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_mem_wdata got=%h exp=deadbeef", mem_wdata); else n_pass++;
        tick();
        l_we = 1'b0;
        #1;
        n_chk++; if (l_rvalid !== 1'b0) $display("FAIL wr_no_rvalid got=%b exp=0", l_rvalid); else n_pass++;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we got=%b exp=0", mem_we); else n_pass++;
        tick();
        l_valid = 1'b0;
        #1;
        n_chk++; if (l_rvalid !== 1'b1) $display("FAIL rd_l_rvalid got=%b exp=1", l_rvalid); else n_pass++;
        n_chk++; if (l_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_l_rdata got=%h exp=deadbeef", l_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midop();
        f_valid = 1'b0; l_valid = 1'b1; l_we = 1'b0; l_lock = 1'b1; l_addr = 32'h3030;
        #1;
        n_chk++; if (l_ready !== 1'b1) $display("FAIL midrst_grant got=%b exp=1", l_ready); else n_pass++;
        tick();
        rst = 1'b1; l_valid = 1'b0; f_valid = 1'b1; f_addr = 32'h3040;
        #1;
        n_chk++; if (f_ready !== 1'b0) $display("FAIL midrst_f_ready got=%b exp=0", f_ready); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (l_rvalid !== 1'b0) $display("FAIL midrst_l_rvalid got=%b exp=0", l_rvalid); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL midrst_locked got=%b exp=0", locked); else n_pass++;
        n_chk++; if (f_ready !== 1'b1) $display("FAIL midrst_lock_released got=%b exp=1", f_ready); else n_pass++;
        tick();
        f_valid = 1'b0; l_lock = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b0; f_valid = 1'b0; l_valid = 1'b0; l_lock = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!f_valid || e_fr) begin
                f_valid = ($urandom % 4) != 0;
                f_addr  = ($urandom % 2) ? $urandom : 32'h3000 + 32'(4 * ($urandom % 16));
            end else if ($urandom % 8 == 0) begin
                f_valid = 1'b0;
            end
            if (!l_valid || e_lr) begin
                l_valid = ($urandom % 3) == 0;
                l_we    = $urandom % 2;
                l_addr  = ($urandom % 2) ? $urandom : 32'h3000 + 32'(4 * ($urandom % 16));
                l_wdata = $urandom;
            end else if ($urandom % 8 == 0) begin
                l_valid = 1'b0;
            end
            l_lock = m_lock ? (($urandom % 8) != 0) : (($urandom % 4) == 0);
            rst    = ($urandom % 64) == 0;
            #1;
            model_comb();
            n_chk++; if (f_ready !== e_fr) $display("FAIL rnd_f_ready c=%0d got=%b exp=%b", c, f_ready, e_fr); else n_pass++;
            n_chk++; if (l_ready !== e_lr) $display("FAIL rnd_l_ready c=%0d got=%b exp=%b", c, l_ready, e_lr); else n_pass++;
            n_chk++; if (mem_we !== e_we) $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, mem_we, e_we); else n_pass++;
            n_chk++; if (mem_addr !== 8'(e_addr)) $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, 8'(e_addr)); else n_pass++;
            if (e_we) begin
                n_chk++; if (mem_wdata !== l_wdata) $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, mem_wdata, l_wdata); else n_pass++;
            end
            n_chk++; if (f_rvalid !== (m_resp == 1)) $display("FAIL rnd_f_rvalid c=%0d got=%b exp=%b", c, f_rvalid, m_resp == 1); else n_pass++;
            n_chk++; if (l_rvalid !== (m_resp == 2)) $display("FAIL rnd_l_rvalid c=%0d got=%b exp=%b", c, l_rvalid, m_resp == 2); else n_pass++;
            if (m_resp == 1) begin
                n_chk++; if (f_rdata !== m_data) $display("FAIL rnd_f_rdata c=%0d got=%h exp=%h", c, f_rdata, m_data); else n_pass++;
            end
            if (m_resp == 2) begin
                n_chk++; if (l_rdata !== m_data) $display("FAIL rnd_l_rdata c=%0d got=%h exp=%h", c, l_rdata, m_data); else n_pass++;
            end
            n_chk++; if (locked !== m_lock) $display("FAIL rnd_locked c=%0d got=%b exp=%b", c, locked, m_lock); else n_pass++;
            tick();
        end
        rst = 1'b0; f_valid = 1'b0; l_valid = 1'b0; l_lock = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sh[i] = pat(i);
        m_lock = 1'b0; m_starve = 0; m_resp = 0; m_data = '0;
        test_reset();
        test_fetch_stream();
        test_starvation();
        test_lock();
        test_write_read();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
